// File: rtl/uart_cmd_parser.sv
// Purpose : buffers UART RX bytes in a small FIFO and parses ASCII line commands
//           ('1'..'9' MOVE, 'R'/'r' RESTART, CR/LF terminated) for the game FSM.
// Latency : cmd_valid rises 2 cycles after the terminator's rx_valid strobe; err/echo at pop+1.
// Backpr. : cmd_valid/cmd_ready handshake; while a command waits the FIFO keeps filling,
//           and a byte arriving while full is dropped and sets the sticky overflow flag.
//
// Ports   : clk, reset (sync, active-high)
//           rx_data[7:0], rx_valid          - byte stream from the UART receiver
//           cmd_valid, cmd_ready            - command handshake to the game FSM
//           cmd_type[1:0], cmd_cell[3:0]    - 00 none / 01 MOVE / 10 RESTART, cell 0..8
//           err                             - one-cycle pulse per rejected line
//           overflow                        - sticky, cleared only by reset
//           echo_data[7:0], echo_valid      - popped-byte echo (UART_CMD_ECHO_EN only, else 0)
// Config  : define UART_CMD_ECHO_EN to build the echo register.
module uart_cmd_parser #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_type,
  output logic [3:0] cmd_cell,
  output logic       err,
  output logic       overflow,
  output logic [7:0] echo_data,
  output logic       echo_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_MOVE    = 2'b01;
  localparam logic [1:0] CMD_RESTART = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_TERM, S_DISCARD, S_OUT} state_t;

  // ---------------- byte FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Fullness uses the pre-cycle count, so a same-cycle pop never rescues a write.
  assign push  = rx_valid && !full;
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (rx_valid && full) overflow <= 1'b1;
    end
  end

  // ---------------- line parser ----------------
  state_t     state_q, state_d;
  logic [1:0] lat_type_q, lat_type_d;
  logic [3:0] lat_cell_q, lat_cell_d;
  logic       err_d;
  logic       head_term, head_digit, head_restart;

  assign head_term    = (head == 8'h0D) || (head == 8'h0A);
  assign head_digit   = (head >= 8'h31) && (head <= 8'h39);
  assign head_restart = (head == 8'h52) || (head == 8'h72);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_type_q <= CMD_NONE;
      lat_cell_q <= 4'd0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_type_q <= lat_type_d;
      lat_cell_q <= lat_cell_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_type_d = lat_type_q;
    lat_cell_d = lat_cell_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_digit) begin
            lat_type_d = CMD_MOVE;
            // ASCII '1'..'9' has low nibble 1..9, giving cell 0..8.
            lat_cell_d = head[3:0] - 4'd1;
            state_d    = S_TERM;
          end else if (head_restart) begin
            lat_type_d = CMD_RESTART;
            lat_cell_d = 4'd0;
            state_d    = S_TERM;
          end else if (!head_term) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
      end
      S_TERM: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_term) begin
            state_d = S_OUT;
          end else begin
            err_d      = 1'b1;
            lat_type_d = CMD_NONE;
            lat_cell_d = 4'd0;
            state_d    = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_term) state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (cmd_ready) begin
          lat_type_d = CMD_NONE;
          lat_cell_d = 4'd0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_valid = (state_q == S_OUT);
  assign cmd_type  = cmd_valid ? lat_type_q : CMD_NONE;
  assign cmd_cell  = cmd_valid ? lat_cell_q : 4'd0;

  // ---------------- optional echo ----------------
`ifdef UART_CMD_ECHO_EN
  logic [7:0] echo_data_q;
  logic       echo_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_data_q  <= 8'h00;
      echo_valid_q <= 1'b0;
    end else begin
      echo_valid_q <= pop;
      if (pop) echo_data_q <= head;
    end
  end

  assign echo_data  = echo_data_q;
  assign echo_valid = echo_valid_q;
`else
  assign echo_data  = 8'h00;
  assign echo_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [1:0] cmd_type;
  logic [3:0] cmd_cell;
  logic       err;
  logic       overflow;
  logic [7:0] echo_data;
  logic       echo_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor records: accepted commands as {type,cell}, and err pulses.
  logic [5:0] got_q[$];
  int         err_cnt = 0;

  logic [5:0] exp_q[$];
  int         exp_err;
  logic [7:0] stream_q[$];
  bit         feed_done;

  uart_cmd_parser #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_cell   (cmd_cell),
    .err        (err),
    .overflow   (overflow),
    .echo_data  (echo_data),
    .echo_valid (echo_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) got_q.push_back({cmd_type, cmd_cell});
    if (err) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---- stimulus helpers (all start and end 1ns after a rising edge) ----
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic bit is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic bit is_cmd_char(input logic [7:0] b);
    return (b >= "1" && b <= "9") || b == "R" || b == "r";
  endfunction

  // Line-level reference: split the stream at terminators; a non-empty line is a
  // command only if it is exactly one command character, otherwise one err.
  task automatic model(input logic [7:0] s[$]);
    logic [7:0] line[$];
    exp_q.delete();
    exp_err = 0;
    foreach (s[i]) begin
      if (is_term(s[i])) begin
        if (line.size() == 1 && is_cmd_char(line[0])) begin
          if (line[0] == "R" || line[0] == "r") exp_q.push_back({2'b10, 4'd0});
          else exp_q.push_back({2'b01, 4'(line[0] - 8'h31)});
        end else if (line.size() > 0) begin
          exp_err++;
        end
        line.delete();
      end else begin
        line.push_back(s[i]);
      end
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    reset = 1'b1;
    cmd_ready = 1'b0;
    tick(2);
    @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_type !== 2'b00) begin n_bad++; $display("FAIL reset_cmd_type got %b want 00", cmd_type); end
    n_cmp++; if (cmd_cell !== 4'd0) begin n_bad++; $display("FAIL reset_cmd_cell got %0d want 0", cmd_cell); end
    n_cmp++; if (err !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags got err=%b ovf=%b want 0/0", err, overflow); end
    n_cmp++; if (echo_valid !== 1'b0 || echo_data !== 8'h00) begin n_bad++; $display("FAIL reset_echo got %b/%h want 0/00", echo_valid, echo_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_move();
    int e0, c0;
    cmd_ready = 1'b1;
    e0 = err_cnt; c0 = got_q.size();
    strobe("5"); tick(3); strobe(8'h0D);
    @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL move_early got %b want 0", cmd_valid); end
    @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_type, cmd_cell} !== {1'b1, 2'b01, 4'd4}) begin n_bad++; $display("FAIL move_cmd got v=%b t=%b c=%0d want 1/01/4", cmd_valid, cmd_type, cmd_cell); end
    @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0 || cmd_type !== 2'b00) begin n_bad++; $display("FAIL move_one_cycle got v=%b t=%b want 0/00", cmd_valid, cmd_type); end
    @(posedge clk); #1; tick(2);
    n_cmp++; if (err_cnt - e0 !== 0 || got_q.size() - c0 !== 1) begin n_bad++; $display("FAIL move_counts got err=%0d cmds=%0d want 0/1", err_cnt - e0, got_q.size() - c0); end
  endtask

  task automatic test_restart();
    int e0, c0;
    cmd_ready = 1'b1;
    e0 = err_cnt; c0 = got_q.size();
    strobe("r"); tick(3); strobe(8'h0D);
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_type, cmd_cell} !== {1'b1, 2'b10, 4'd0}) begin n_bad++; $display("FAIL restart_cmd got v=%b t=%b c=%0d want 1/10/0", cmd_valid, cmd_type, cmd_cell); end
    @(posedge clk); #1;
    strobe(8'h0A); tick(5);
    n_cmp++; if (err_cnt - e0 !== 0 || got_q.size() - c0 !== 1) begin n_bad++; $display("FAIL restart_counts got err=%0d cmds=%0d want 0/1", err_cnt - e0, got_q.size() - c0); end
  endtask

  task automatic test_bad_first();
    int e0, c0;
    cmd_ready = 1'b1;
    e0 = err_cnt; c0 = got_q.size();
    strobe("0");
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bad_first_err_early got %b want 0", err); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_first_err_pulse got %b want 1", err); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bad_first_err_width got %b want 0", err); end
    @(posedge clk); #1;
    strobe("7"); tick(3); strobe(8'h0D); tick(4);
    n_cmp++; if (err_cnt - e0 !== 1 || got_q.size() - c0 !== 0) begin n_bad++; $display("FAIL bad_first_counts got err=%0d cmds=%0d want 1/0", err_cnt - e0, got_q.size() - c0); end
    strobe("2"); tick(3); strobe(8'h0D); tick(4);
    n_cmp++; if (got_q.size() - c0 !== 1 || got_q[got_q.size()-1] !== {2'b01, 4'd1}) begin n_bad++; $display("FAIL bad_first_recover got cmds=%0d want 1 MOVE cell 1", got_q.size() - c0); end
  endtask

  task automatic test_bad_term();
    int e0, c0;
    cmd_ready = 1'b1;
    e0 = err_cnt; c0 = got_q.size();
    strobe("3"); tick(3); strobe("4");
    @(negedge clk); @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_term_err_pulse got %b want 1", err); end
    @(posedge clk); #1;
    strobe(8'h0D); tick(4);
    n_cmp++; if (err_cnt - e0 !== 1 || got_q.size() - c0 !== 0) begin n_bad++; $display("FAIL bad_term_counts got err=%0d cmds=%0d want 1/0", err_cnt - e0, got_q.size() - c0); end
  endtask

  task automatic test_overflow();
    int e0, c0;
    logic [7:0] fill[4];
    fill = '{"2", 8'h0D, "x", 8'h0D};
    cmd_ready = 1'b0;
    strobe("1"); tick(3); strobe(8'h0D); tick(3);
    @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_type, cmd_cell} !== {1'b1, 2'b01, 4'd0}) begin n_bad++; $display("FAIL ovf_hold got v=%b t=%b c=%0d want 1/01/0", cmd_valid, cmd_type, cmd_cell); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin strobe(fill[i]); tick(1); end
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_not_yet got %b want 0", overflow); end
    @(posedge clk); #1;
    strobe("8");
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow); end
    @(posedge clk); #1; tick(3);
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_cell !== 4'd0) begin n_bad++; $display("FAIL ovf_still_held got v=%b c=%0d want 1/0", cmd_valid, cmd_cell); end
    e0 = err_cnt; c0 = got_q.size();
    cmd_ready = 1'b1;
    tick(20);
    n_cmp++; if (got_q.size() - c0 !== 2) begin n_bad++; $display("FAIL ovf_drain_count got %0d want 2", got_q.size() - c0); end
    else begin
      n_cmp++; if (got_q[c0] !== {2'b01, 4'd0} || got_q[c0+1] !== {2'b01, 4'd1}) begin n_bad++; $display("FAIL ovf_drain_order got %h,%h want 10,11", got_q[c0], got_q[c0+1]); end
    end
    n_cmp++; if (err_cnt - e0 !== 1 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_after got err=%0d ovf=%b want 1/1", err_cnt - e0, overflow); end
  endtask

  task automatic test_reset_mid();
    int e0, c0;
    cmd_ready = 1'b1;
    strobe("9"); tick(3);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_type, cmd_cell, err, overflow} !== 9'd0) begin n_bad++; $display("FAIL reset_mid_outputs got v=%b t=%b c=%0d e=%b o=%b want all 0", cmd_valid, cmd_type, cmd_cell, err, overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    e0 = err_cnt; c0 = got_q.size();
    strobe(8'h0D); tick(5);
    n_cmp++; if (err_cnt - e0 !== 0 || got_q.size() - c0 !== 0) begin n_bad++; $display("FAIL reset_mid_after got err=%0d cmds=%0d want 0/0", err_cnt - e0, got_q.size() - c0); end
  endtask

  task automatic test_random();
    int e0, c0, kind, extra;
    logic [7:0] b;
    stream_q.delete();
    for (int l = 0; l < 30; l++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: stream_q.push_back(8'("1" + $urandom_range(0, 8)));
        1: stream_q.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
        2, 3: begin
          if (kind == 2) begin
            do b = 8'($urandom_range(0, 255)); while (is_term(b) || is_cmd_char(b));
            extra = $urandom_range(0, 2);
          end else begin
            b = 8'("1" + $urandom_range(0, 8));
            extra = $urandom_range(1, 2);
          end
          stream_q.push_back(b);
          for (int k = 0; k < extra; k++) begin
            do b = 8'($urandom_range(0, 255)); while (is_term(b));
            stream_q.push_back(b);
          end
        end
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0: stream_q.push_back(8'h0D);
        1: stream_q.push_back(8'h0A);
        default: begin stream_q.push_back(8'h0D); stream_q.push_back(8'h0A); end
      endcase
    end
    model(stream_q);
    e0 = err_cnt; c0 = got_q.size();
    feed_done = 1'b0;
    fork
      begin
        foreach (stream_q[i]) begin strobe(stream_q[i]); tick(3); end
        feed_done = 1'b1;
      end
      begin
        while (!feed_done) begin
          cmd_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    cmd_ready = 1'b1;
    tick(30);
    n_cmp++; if (got_q.size() - c0 !== exp_q.size()) begin n_bad++; $display("FAIL rand_cmd_count got %0d want %0d", got_q.size() - c0, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[c0+i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_cmd[%0d] got %h want %h", i, got_q[c0+i], exp_q[i]); end
      end
    end
    n_cmp++; if (err_cnt - e0 !== exp_err) begin n_bad++; $display("FAIL rand_err_count got %0d want %0d", err_cnt - e0, exp_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand_overflow got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_restart();
    test_bad_first();
    test_bad_term();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Sits directly downstream of the UART receiver in the Nexys A7 tic-tac-toe design. Buffers received bytes in a small FIFO, parses ASCII line commands (cell digit or restart), and presents one decoded command at a time to the game FSM over a valid/ready handshake. Flags malformed lines and FIFO overflow.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of two and at least 2.
- `clk` input, 1: system clock, 25 MHz.
- `reset` input, 1: synchronous, active-high reset.
- `rx_data` input, 8: received byte. Qualified by `rx_valid`.
- `rx_valid` input, 1: single-cycle strobe from the receiver.
- `cmd_valid` output, 1: a decoded command is presented.
- `cmd_ready` input, 1: game FSM accepts the command.
- `cmd_type` output, 2: command type. 00 = none, 01 = MOVE, 10 = RESTART.
- `cmd_cell` output, 4: cell index 0..8 for MOVE; 0 for RESTART.
- `err` output, 1: one-cycle pulse when a line is rejected.
- `overflow` output, 1: sticky flag set when a byte is dropped because the FIFO was full.
- `echo_data` output, 8: copy of the byte just consumed (`UART_CMD_ECHO_EN` only).
- `echo_valid` output, 1: one-cycle strobe for `echo_data`.

## Operation
**FIFO**
- Write when `rx_valid` is high and the FIFO is not full.
- Fullness is judged on the pre-cycle count. A write while full is dropped and sets `overflow`, even if a pop happens in the same cycle.
- Head byte is read combinationally.
- The FSM pops at most one byte per cycle, only in IDLE, TERM or DISCARD, and only when the FIFO is not empty.

**Terminator** is 0x0D or 0x0A.

**FSM states and transitions (evaluated on the popped byte)**
- IDLE:
  - 0x31..0x39: latch MOVE, cell = byte − 0x31, go to TERM.
  - 0x52 or 0x72: latch RESTART, cell = 0, go to TERM.
  - Terminator: ignored, stay in IDLE. This makes CRLF and blank lines harmless.
  - Any other byte: pulse `err`, go to DISCARD.
- TERM:
  - Terminator: go to OUT.
  - Any other byte: pulse `err`, clear the latched command, go to DISCARD.
- DISCARD:
  - Terminator: go to IDLE, no further `err`.
  - Any other byte: consume silently.
- OUT:
  - `cmd_valid` = 1; `cmd_type` and `cmd_cell` are held stable.
  - No pops; the FIFO keeps accepting writes.
  - On `cmd_valid && cmd_ready`: go to IDLE next cycle with `cmd_type` = 00. The FSM may pop in that IDLE cycle.

**Outputs and reset**
- `cmd_type` = 00 and `cmd_cell` = 0 whenever not in OUT.
- Reset values: state IDLE, FIFO empty, `cmd_valid` 0, `cmd_type` 00, `cmd_cell` 0, `err` 0, `overflow` 0, `echo_data` 0x00, `echo_valid` 0.
- A reset mid-line or while in OUT discards all buffered and partially parsed data.
- `overflow` clears only on reset.

## Timing
- A byte strobed at cycle N is in the FIFO at N+1. With the FSM not in OUT and the FIFO otherwise empty, it is popped at N+1, and the state update is visible at N+2.
- `cmd_valid` rises 2 cycles after the terminator's `rx_valid`.
- `err` is asserted for exactly 1 cycle, at pop+1.
- `echo_valid` is asserted at pop+1.
- Minimum spacing of receiver strobes at 9600 baud is 26040 cycles, so the FIFO only fills while `cmd_ready` is withheld.

## Configuration
- `UART_CMD_ECHO_EN` defined:
  - Every popped byte, including terminators and discarded bytes, is registered onto `echo_data` with a one-cycle `echo_valid`.
  - Intended for feeding the transmitter for terminal echo.
- `UART_CMD_ECHO_EN` undefined:
  - `echo_valid` and `echo_data` are tied to 0.
  - No echo register is instantiated.

## Test plan
- Reset, then send '5', 0x0D with `cmd_ready` = 1 → `cmd_valid` high for 1 cycle, 2 cycles after the 0x0D strobe, with `cmd_type` = 01, `cmd_cell` = 4. `err` stays 0.
- Send 'r', 0x0D, 0x0A → one RESTART command (`cmd_type` = 10, `cmd_cell` = 0). The 0x0A is ignored and produces no second command and no `err`.
- Send '0', '7', 0x0D → `err` pulses once on the '0' pop. No command is produced. The parser returns to IDLE after 0x0D.
- Send '3', '4', 0x0D → `err` pulses once on the '4' pop. No command is produced.
- Hold `cmd_ready` = 0 after '1', 0x0D, then send 5 more bytes with `FIFO_DEPTH` = 4:
  - `cmd_valid` is held with `cmd_cell` = 0.
  - The 5th byte is dropped and `overflow` becomes 1 and stays 1.
  - Releasing `cmd_ready` drains the 4 buffered bytes in order.
- Assert `reset` while in TERM after '9' → all outputs return to reset values. A following 0x0D produces no command.
